// File: rtl/adder_share_arb.sv
// adder_share_arb: NREQ requesters share a single registered WIDTH-bit adder.
// A transaction is accepted in IDLE, summed in CALC and presented in RESP
// until the consumer takes it.
// Build option: define ADDER_SHARE_ARB_RR_EN for round-robin arbitration;
// when it is left undefined the lowest-indexed valid requester always wins.

module adder_share_arb #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [2:0]            rsp_id,
    output logic [WIDTH:0]        rsp_sum,
    output logic [15:0]           ops_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_id;
    logic [WIDTH:0]   r_sum;
    logic             r_rsp_valid;
    logic [15:0]      r_ops_count;

    logic [NREQ-1:0]  w_grant;
    logic [2:0]       w_grant_idx;
    logic             w_grant_any;
    logic             w_accept;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;

`ifdef ADDER_SHARE_ARB_RR_EN
    logic [2:0]       r_ptr;

    // Round-robin search: the first valid requester at or after the pointer wins.
    always_comb begin
        w_grant     = '0;
        w_grant_idx = '0;
        w_grant_any = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!w_grant_any && req_valid[j] &&
                    ((int'(r_ptr) + k == j) || (int'(r_ptr) + k == j + NREQ))) begin
                    w_grant_any = 1'b1;
                    w_grant[j]  = 1'b1;
                    w_grant_idx = 3'(j);
                end
            end
        end
    end

    // Move the pointer just past the winner, but only when a request is taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            if (w_grant_idx == 3'(NREQ - 1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= w_grant_idx + 3'd1;
            end
        end
    end
`else
    // Fixed priority: the lowest-indexed valid requester wins every time.
    always_comb begin
        w_grant     = '0;
        w_grant_idx = '0;
        w_grant_any = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (!w_grant_any && req_valid[j]) begin
                w_grant_any = 1'b1;
                w_grant[j]  = 1'b1;
                w_grant_idx = 3'(j);
            end
        end
    end
`endif

    // The grant can only be offered while the adder is idle; in the same cycle
    // the requester sees it, so this path stays combinational from the state.
    assign req_ready = (r_state == IDLE) ? w_grant : '0;
    assign w_accept  = |(req_valid & req_ready);

    // Steer the granted requester's operands toward the capture registers.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (w_grant[j]) begin
                w_sel_a = req_a[j*WIDTH +: WIDTH];
                w_sel_b = req_b[j*WIDTH +: WIDTH];
            end
        end
    end

    // Transaction FSM: capture in IDLE, add in CALC, hold the result in RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_id        <= '0;
            r_sum       <= '0;
            r_rsp_valid <= 1'b0;
            r_ops_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= w_sel_a;
                        r_b     <= w_sel_b;
                        r_id    <= w_grant_idx;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_sum       <= {1'b0, r_a} + {1'b0, r_b};
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                        if (r_ops_count != 16'hFFFF) begin
                            r_ops_count <= r_ops_count + 16'd1;
                        end
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_id;
    assign rsp_sum   = r_sum;
    assign ops_count = r_ops_count;

endmodule
